// File: rtl/demux_pkg.sv
// Shared lane-count constants and lane index type for the 1-to-8 demux.
package demux_pkg;
    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef logic [SEL_W-1:0] lane_idx_t;
endpackage

// File: rtl/one_to_eight_demux_if.sv
// Data, control and collection-status bundle between a producer and the demux.
interface one_to_eight_demux_if #(
    parameter int WIDTH = 1
);
    import demux_pkg::*;

    logic [WIDTH-1:0]           in;
    logic                       in_valid;
    lane_idx_t                  sel;
    logic                       auto_mode;
    logic                       clear;
    logic [NUM_LANES*WIDTH-1:0] out;
    logic [NUM_LANES-1:0]       lane_valid;
    logic                       word_valid;
    lane_idx_t                  ptr;

    modport master (
        output in, in_valid, sel, auto_mode, clear,
        input  out, lane_valid, word_valid, ptr
    );

    modport slave (
        input  in, in_valid, sel, auto_mode, clear,
        output out, lane_valid, word_valid, ptr
    );
endinterface

// File: rtl/one_to_eight_demux_sel_decoder.sv
// Lane index to one-hot write enable, all zero when not enabled.
module sel_decoder
    import demux_pkg::*;
(
    input  lane_idx_t            idx,
    input  logic                 enable,
    output logic [NUM_LANES-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (enable) begin
            onehot[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/one_to_eight_demux.sv
// Routes one input word per write into one of eight registered lanes and
// flags when all eight lanes of a word have been collected.
module one_to_eight_demux
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic                clk,
    input logic                rst_n,
    one_to_eight_demux_if.slave bus
);
    logic [NUM_LANES*WIDTH-1:0] out_q;
    logic [NUM_LANES-1:0]       lv_q;
    logic [NUM_LANES-1:0]       lv_next;
    logic [NUM_LANES-1:0]       we;
    logic                       wv_q;
    lane_idx_t                  ptr_q;
    lane_idx_t                  lane;
    logic                       mode_q;
    logic                       flush;
    logic                       wr;
    logic                       full;

    // A mode flip restarts collection exactly like an explicit clear.
    always_comb begin
        flush   = bus.clear | (bus.auto_mode != mode_q);
        wr      = bus.in_valid & ~flush;
        lane    = bus.auto_mode ? ptr_q : bus.sel;
        lv_next = lv_q | we;
        full    = wr & (&lv_next);
    end

    sel_decoder u_dec (
        .idx    (lane),
        .enable (wr),
        .onehot (we)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (we[k]) begin
                    out_q[k*WIDTH +: WIDTH] <= bus.in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lv_q   <= '0;
            wv_q   <= 1'b0;
            ptr_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            mode_q <= bus.auto_mode;
            if (flush) begin
                lv_q  <= '0;
                wv_q  <= 1'b0;
                ptr_q <= '0;
            end else begin
                wv_q <= full;
                lv_q <= full ? '0 : lv_next;
                if (!bus.auto_mode) begin
                    ptr_q <= '0;
                end else if (wr) begin
                    ptr_q <= ptr_q + SEL_W'(1);
                end
            end
        end
    end

    assign bus.out        = out_q;
    assign bus.lane_valid = lv_q;
    assign bus.word_valid = wv_q;
    assign bus.ptr        = ptr_q;
endmodule

// File: tb/tb_one_to_eight_demux.sv
// Directed table, corner sequences and random traffic for one_to_eight_demux.
module tb_one_to_eight_demux;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    one_to_eight_demux_if #(.WIDTH(1)) bus ();

    one_to_eight_demux #(.WIDTH(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       r;
        bit       iv;
        bit       d;
        bit [2:0] s;
        bit       am;
        bit       cl;
        bit [7:0] e_out;
        bit [7:0] e_lv;
        bit       e_wv;
        bit [2:0] e_ptr;
    } vec_t;

    vec_t tbl[19];

    // Behavioural reference: lanes as arrays, word completion by counting.
    bit m_lane[8];
    bit m_val[8];
    bit m_wv;
    int m_ptr;
    bit m_mode;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model(input bit r, iv, d, input bit [2:0] s,
                         input bit am, cl);
        int L;
        int cnt;
        if (!r) begin
            for (int k = 0; k < 8; k++) begin
                m_lane[k] = 0;
                m_val[k]  = 0;
            end
            m_wv = 0; m_ptr = 0; m_mode = 0;
            return;
        end
        if (cl || am != m_mode) begin
            for (int k = 0; k < 8; k++) m_val[k] = 0;
            m_wv = 0; m_ptr = 0; m_mode = am;
            return;
        end
        m_mode = am;
        m_wv = 0;
        if (iv) begin
            L = am ? m_ptr : int'(s);
            m_lane[L] = d;
            m_val[L]  = 1;
            cnt = 0;
            for (int k = 0; k < 8; k++) cnt += int'(m_val[k]);
            if (cnt == 8) begin
                m_wv = 1;
                for (int k = 0; k < 8; k++) m_val[k] = 0;
            end
            if (am) m_ptr = (m_ptr + 1) % 8;
        end
        if (!am) m_ptr = 0;
    endtask

    function automatic logic [7:0] pack(input bit a[8]);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = a[k];
        return v;
    endfunction

    task automatic drive(input bit r, iv, d, input bit [2:0] s,
                         input bit am, cl);
        rst_n         = r;
        bus.in_valid  = iv;
        bus.in        = d;
        bus.sel       = s;
        bus.auto_mode = am;
        bus.clear     = cl;
    endtask

    task automatic cycle(input bit r, iv, d, input bit [2:0] s,
                         input bit am, cl);
        drive(r, iv, d, s, am, cl);
        @(posedge clk);
        model(r, iv, d, s, am, cl);
        #1;
        check("out", 32'(bus.out), 32'(pack(m_lane)));
        check("lane_valid", 32'(bus.lane_valid), 32'(pack(m_val)));
        check("word_valid", 32'(bus.word_valid), 32'(m_wv));
        check("ptr", 32'(bus.ptr), 32'(m_ptr));
    endtask

    initial begin
        int       wv_cnt;
        bit [15:0] mask;
        bit       am;
        bit       bits8[8];

        bits8 = '{1, 0, 1, 1, 0, 0, 1, 0};
        //         r iv d s  am cl  out    lv     wv ptr
        tbl[0]  = '{0, 1, 1, 5, 0, 0, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 1, 1, 8'h00, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 1, 0, 8'h01, 8'h01, 0, 1};
        tbl[4]  = '{1, 1, 0, 0, 1, 0, 8'h01, 8'h03, 0, 2};
        tbl[5]  = '{1, 1, 1, 0, 1, 0, 8'h05, 8'h07, 0, 3};
        tbl[6]  = '{1, 1, 1, 0, 1, 0, 8'h0D, 8'h0F, 0, 4};
        tbl[7]  = '{1, 1, 0, 0, 1, 0, 8'h0D, 8'h1F, 0, 5};
        tbl[8]  = '{1, 1, 0, 0, 1, 0, 8'h0D, 8'h3F, 0, 6};
        tbl[9]  = '{1, 1, 1, 0, 1, 0, 8'h4D, 8'h7F, 0, 7};
        tbl[10] = '{1, 1, 0, 0, 1, 0, 8'h4D, 8'h00, 1, 0};
        tbl[11] = '{1, 0, 0, 0, 1, 0, 8'h4D, 8'h00, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 8'h4D, 8'h00, 0, 0};
        tbl[13] = '{1, 1, 1, 7, 0, 0, 8'hCD, 8'h80, 0, 0};
        tbl[14] = '{1, 1, 1, 3, 0, 0, 8'hCD, 8'h88, 0, 0};
        tbl[15] = '{1, 1, 0, 3, 0, 0, 8'hC5, 8'h88, 0, 0};
        tbl[16] = '{1, 1, 1, 0, 0, 0, 8'hC5, 8'h89, 0, 0};
        tbl[17] = '{1, 0, 1, 2, 0, 0, 8'hC5, 8'h89, 0, 0};
        tbl[18] = '{0, 1, 1, 2, 0, 0, 8'h00, 8'h00, 0, 0};

        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].s,
                  tbl[i].am, tbl[i].cl);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_out", i), 32'(bus.out), 32'(tbl[i].e_out));
            check($sformatf("tbl%0d_lv", i), 32'(bus.lane_valid), 32'(tbl[i].e_lv));
            check($sformatf("tbl%0d_wv", i), 32'(bus.word_valid), 32'(tbl[i].e_wv));
            check($sformatf("tbl%0d_ptr", i), 32'(bus.ptr), 32'(tbl[i].e_ptr));
        end

        // Clear colliding with a write, then a full word.
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, bits8[i], 0, 1, 0);
        cycle(1, 1, 1, 0, 1, 1);
        check("clr_lv", 32'(bus.lane_valid), 32'h0);
        check("clr_ptr", 32'(bus.ptr), 32'h0);
        check("clr_out", 32'(bus.out), 32'h0D);
        wv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, bits8[7-i], 0, 1, 0);
            wv_cnt += int'(bus.word_valid);
        end
        check("clr_wv_count", 32'(wv_cnt), 32'd1);

        // Mode switch discards the write in that cycle.
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 1, 0);
        cycle(1, 1, 0, 2, 0, 0);
        check("msw_lv", 32'(bus.lane_valid), 32'h0);
        check("msw_ptr", 32'(bus.ptr), 32'h0);

        // Back-to-back: pulses after the 8th and 16th write.
        cycle(1, 0, 0, 0, 1, 0);
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 1'($urandom), 0, 1, 0);
            mask[i] = bus.word_valid;
        end
        check("b2b_pulses", 32'(mask), 32'h8080);

        // Random traffic.
        am = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) am = ~am;
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 3) != 0,
                  1'($urandom),
                  3'($urandom),
                  am,
                  $urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/one_to_eight_demux.md
ONE_TO_EIGHT_DEMUX -- requirements
Module: one_to_eight_demux

Interface
REQ-001 SHALL have parameter: WIDTH, 1, bit width of each lane.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: in  input  WIDTH  data to route to one lane.
REQ-005 SHALL have port: in_valid  input  1  write strobe for in.
REQ-006 SHALL have port: sel  input  3  target lane in addressed mode; ignored in auto mode.
REQ-007 SHALL have port: auto_mode  input  1  0 = addressed (sel), 1 = sequential internal pointer.
REQ-008 SHALL have port: clear  input  1  synchronous flush of collection state.
REQ-009 SHALL have port: out  output  8*WIDTH  lane k at out[k*WIDTH +: WIDTH], registered.
REQ-010 SHALL have port: lane_valid  output  8  bit k set when lane k written in current word.
REQ-011 SHALL have port: word_valid  output  1  one-cycle pulse, all 8 lanes collected.
REQ-012 SHALL have port: ptr  output  3  current auto-mode write pointer.

Function
REQ-013 SHALL, on an edge with in_valid=1 and clear=0, load in into lane L (L = sel if auto_mode=0, else ptr); out visible the following cycle (latency 1).
REQ-014 SHALL leave lanes other than L, and all lanes when in_valid=0, unchanged.
REQ-015 SHALL set lane_valid[L] on each write; rewriting an already-valid lane overwrites data, lane_valid unchanged.
REQ-016 SHALL, in auto mode, increment ptr on every accepted write, wrapping 7 -> 0; ptr holds otherwise.
REQ-017 SHALL, in addressed mode, hold ptr at 0.
REQ-018 SHALL, on the edge where a write makes lane_valid all ones, assert word_valid for exactly the next cycle and clear lane_valid to 8'h00 on that same edge; out retains the completed word.
REQ-019 SHALL deassert word_valid in every cycle not covered by REQ-018.
REQ-020 SHALL, when clear=1, zero lane_valid and ptr, suppress word_valid, discard any simultaneous write, and keep out unchanged.
REQ-021 SHALL treat a change of auto_mode (compared to its value registered last cycle) as an implicit clear; a write in that cycle is discarded.
REQ-022 SHALL allow back-to-back writes every cycle, including a write in the cycle word_valid is high (that write starts the next word).

Reset
REQ-023 SHALL, when rst_n=0 at a clock edge, set out=0, lane_valid=8'h00, word_valid=0, ptr=0, registered auto_mode=0; reset overrides clear and in_valid.
REQ-024 SHALL produce no output change between edges; reset asserted mid-word discards partial collection.

Structure
REQ-025 SHALL take NUM_LANES=8, SEL_W=3 and the lane-index type from shared package demux_pkg.
REQ-026 SHALL instantiate one sub-module sel_decoder (3-bit index -> 8-bit one-hot write enable, gated by enable input).
REQ-027 SHALL contain no latches and no combinational path from in to out.

Verification
REQ-028 Reset: rst_n=0 two cycles with in_valid=1 -> out=0, lane_valid=0, word_valid=0, ptr=0.
REQ-029 Auto word: auto_mode=1, 8 consecutive writes in=1,0,1,1,0,0,1,0 -> out=8'b01001101, word_valid high one cycle after 8th write, ptr back to 0, lane_valid=0.
REQ-030 Addressed: writes sel=7,3,3,0 with in=1,1,0,1 -> out[7]=1, out[3]=0, out[0]=1, lane_valid=8'h89, no word_valid.
REQ-031 Clear collision: auto mode, 5 writes then clear=1 with in_valid=1 -> lane_valid=0, ptr=0, out unchanged, next 8 writes produce word_valid once.
REQ-032 Mode switch: 3 auto writes then auto_mode=0 with in_valid=1 -> write discarded, lane_valid=0, ptr=0.
REQ-033 Back-to-back: 16 continuous auto writes -> word_valid pulses exactly at cycles 9 and 17 after first write, no gap.
